axis_lrelu_frame_tx: RTL

- Transmit side of the LReLU-engine input protocol.
- Merges a config stream and a conv-output data stream into one AXIS stream.
- Each iteration is sent as: N config beats (kw2 carried in tuser on the first beat), then data beats, with tlast on the final data beat.
- Sits between the conv core / config DMA and the LReLU engine slave port.

---
 rtl/axis_lrelu_frame_tx_pkg.sv | 25 ++
 rtl/axis_lrelu_frame_tx_if.sv | 20 ++
 rtl/axis_lrelu_frame_tx_skid_buffer.sv | 55 +++++
 rtl/axis_lrelu_frame_tx.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/axis_lrelu_frame_tx_pkg.sv
// Shared widths, tuser field layout and FSM encoding for the LReLU frame transmitter.
package axis_lrelu_frame_tx_pkg;

    localparam int unsigned WORD_WIDTH_ACC       = 8;
    localparam int unsigned COPIES               = 1;
    localparam int unsigned GROUPS               = 1;
    localparam int unsigned MEMBERS              = 2;
    localparam int unsigned UNITS                = 2;
    localparam int unsigned TUSER_WIDTH_LRELU_IN = 4;
    localparam int unsigned I_KW2                = 1;
    localparam int unsigned BITS_KW2             = 2;
    localparam int unsigned TUSER_W              = MEMBERS * TUSER_WIDTH_LRELU_IN;
    localparam int unsigned CNT_W                = 8;

    typedef enum logic [1:0] {
        StCfgHead = 2'd0,
        StCfgBody = 2'd1,
        StData    = 2'd2
    } state_e;

    function automatic int unsigned bus_width(input int unsigned zero);
        return COPIES * GROUPS * MEMBERS * UNITS * (WORD_WIDTH_ACC + zero);
    endfunction

endpackage

// File: rtl/axis_lrelu_frame_tx_if.sv
// AXI-Stream bundle shared by the config, data and engine-facing ports.
interface axis_lrelu_frame_tx_if #(
    parameter int unsigned ZERO = 0
) ();
    import axis_lrelu_frame_tx_pkg::*;

    localparam int unsigned W = bus_width(ZERO);

    logic                tvalid;
    logic                tready;
    logic [W-1:0]        tdata;
    logic [W/8-1:0]      tkeep;
    logic [TUSER_W-1:0]  tuser;
    logic                tlast;
    logic [BITS_KW2-1:0] kw2;

    modport master (output tvalid, tdata, tkeep, tuser, tlast, kw2, input tready);
    modport slave  (input tvalid, tdata, tkeep, tuser, tlast, kw2, output tready);

endinterface

// File: rtl/axis_lrelu_frame_tx_skid_buffer.sv
// Two-entry skid buffer with fully registered outputs; upstream ready is a flop output.
module axis_skid_buffer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
);

    logic             run_q;
    logic             out_valid_q;
    logic             skid_valid_q;
    logic [Width-1:0] out_data_q;
    logic [Width-1:0] skid_data_q;
    logic             push;
    logic             load;

    // run_q keeps ready low while in reset and for the cycle it is released.
    assign in_ready  = run_q && !skid_valid_q;
    assign push      = in_valid && in_ready;
    assign load      = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            run_q <= 1'b1;
            if (load) begin
                if (skid_valid_q) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= skid_data_q;
                    skid_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= push;
                    if (push) out_data_q <= in_data;
                end
            end else if (push) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= in_data;
            end
        end
    end

endmodule

// File: rtl/axis_lrelu_frame_tx.sv
// Merges config and conv-output streams into one LReLU-engine AXIS frame:
// a fixed number of config beats (kw2 in tuser) followed by the data beats.
module axis_lrelu_frame_tx
    import axis_lrelu_frame_tx_pkg::*;
#(
    parameter int unsigned ZERO        = 0,
    parameter int unsigned BEATS_1X1   = 2,
    parameter int unsigned BEATS_KXK   = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    axis_lrelu_frame_tx_if.slave   s_cfg,
    axis_lrelu_frame_tx_if.slave   s_data,
    axis_lrelu_frame_tx_if.master  m_axis,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic                   cfg_error,
    output logic [1:0]             state_dbg
);

    localparam int unsigned W  = bus_width(ZERO);
    localparam int unsigned KW = W / 8;
    localparam int unsigned PW = W + KW + TUSER_W + 1;

    // Head and last body beat are not counted, hence the -2.
    localparam logic [CNT_W-1:0] CNT_1X1 = CNT_W'(BEATS_1X1 - 2);
    localparam logic [CNT_W-1:0] CNT_KXK = CNT_W'(BEATS_KXK - 2);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BITS_KW2-1:0]     kw2_q, kw2_d;
    logic [COUNT_WIDTH-1:0]  frame_count_q, frame_count_d;
    logic                    cfg_error_q, cfg_error_d;

    logic                    out_ready;
    logic                    in_valid;
    logic                    cfg_ready;
    logic                    data_ready;
    logic                    cfg_hs;
    logic                    data_hs;
    logic [W-1:0]            p_tdata;
    logic [KW-1:0]           p_tkeep;
    logic [TUSER_W-1:0]      p_tuser;
    logic                    p_tlast;
    logic [PW-1:0]           out_payload;

    assign cfg_hs  = s_cfg.tvalid && out_ready;
    assign data_hs = s_data.tvalid && out_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        kw2_d         = kw2_q;
        frame_count_d = frame_count_q;
        cfg_error_d   = cfg_error_q;
        cfg_ready     = 1'b0;
        data_ready    = 1'b0;
        in_valid      = 1'b0;
        p_tdata       = s_cfg.tdata;
        p_tkeep       = '1;
        p_tuser       = '0;
        p_tlast       = 1'b0;
        unique case (state_q)
            StCfgHead: begin
                cfg_ready                    = out_ready;
                in_valid                     = s_cfg.tvalid;
                p_tuser[I_KW2 +: BITS_KW2]   = s_cfg.kw2;
                if (cfg_hs) begin
                    kw2_d   = s_cfg.kw2;
                    cnt_d   = (s_cfg.kw2 == '0) ? CNT_1X1 : CNT_KXK;
                    state_d = StCfgBody;
                    if (s_cfg.tlast) cfg_error_d = 1'b1;
                end
            end
            StCfgBody: begin
                cfg_ready                    = out_ready;
                in_valid                     = s_cfg.tvalid;
                p_tuser[I_KW2 +: BITS_KW2]   = kw2_q;
                // Frame length is purely count-driven; tlast only feeds the error flag.
                if (cfg_hs) begin
                    if (cnt_q == '0) begin
                        if (!s_cfg.tlast) cfg_error_d = 1'b1;
                        state_d = StData;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (s_cfg.tlast) cfg_error_d = 1'b1;
                    end
                end
            end
            StData: begin
                data_ready = out_ready;
                in_valid   = s_data.tvalid;
                p_tdata    = s_data.tdata;
                p_tkeep    = s_data.tkeep;
                p_tuser    = s_data.tuser;
                p_tlast    = s_data.tlast;
                if (data_hs && s_data.tlast) begin
                    frame_count_d = frame_count_q + COUNT_WIDTH'(1);
                    state_d       = StCfgHead;
                end
            end
            default: state_d = StCfgHead;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= StCfgHead;
            cnt_q         <= '0;
            kw2_q         <= '0;
            frame_count_q <= '0;
            cfg_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            kw2_q         <= kw2_d;
            frame_count_q <= frame_count_d;
            cfg_error_q   <= cfg_error_d;
        end
    end

    axis_skid_buffer #(
        .Width (PW)
    ) u_skid (
        .clk       (aclk),
        .rst       (areset),
        .in_valid  (in_valid),
        .in_ready  (out_ready),
        .in_data   ({p_tdata, p_tkeep, p_tuser, p_tlast}),
        .out_valid (m_axis.tvalid),
        .out_ready (m_axis.tready),
        .out_data  (out_payload)
    );

    assign {m_axis.tdata, m_axis.tkeep, m_axis.tuser, m_axis.tlast} = out_payload;
    assign m_axis.kw2    = '0;
    assign s_cfg.tready  = cfg_ready;
    assign s_data.tready = data_ready;
    assign frame_count   = frame_count_q;
    assign cfg_error     = cfg_error_q;
    assign state_dbg     = state_q;

    logic unused_inputs;
    assign unused_inputs = ^{s_cfg.tkeep, s_cfg.tuser, s_data.kw2};

endmodule
